hw_fifo_dma_bridge: RTL and testbench

//  DMA-side front end of the streaming interface: one engine per DMA channel that moves a

---
 rtl/hw_fifo_dma_bridge_pkg.sv | 28 ++
 rtl/hw_fifo_dma_bridge_if.sv | 32 +++
 rtl/hw_fifo_dma_bridge_ch.sv | 99 +++++++++
 rtl/hw_fifo_dma_bridge.sv | 49 ++++
 tb/tb_hw_fifo_dma_bridge.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hw_fifo_dma_bridge_pkg.sv
// Shared types and constants for the DMA-side FIFO bridge: channel count, length width,
// channel FSM states and the HW FIFO request/response records.
package hw_fifo_dma_bridge_pkg;

  localparam int N_DMA_CH  = 2;
  localparam int DMA_LEN_W = 16;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_ch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              push;
    logic              pop;
  } hw_fifo_req_t;

  typedef struct packed {
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] data;
    logic              push;
  } hw_fifo_resp_t;

endpackage

// File: rtl/hw_fifo_dma_bridge_if.sv
// Bundle of control, DMA beat and HW FIFO signals for all bridge channels.
// The bridge sits on the slave side; software/DMA/FIFO models drive the master side.
interface hw_fifo_dma_bridge_if;
  import hw_fifo_dma_bridge_pkg::*;

  logic          [N_DMA_CH-1:0]                ch_type;
  logic          [N_DMA_CH-1:0]                start;
  logic          [N_DMA_CH-1:0][DMA_LEN_W-1:0] len;
  logic          [N_DMA_CH-1:0]                abort;
  logic          [N_DMA_CH-1:0]                rx_valid;
  logic          [N_DMA_CH-1:0][DATA_W-1:0]    rx_data;
  logic          [N_DMA_CH-1:0]                rx_ready;
  logic          [N_DMA_CH-1:0]                tx_valid;
  logic          [N_DMA_CH-1:0][DATA_W-1:0]    tx_data;
  logic          [N_DMA_CH-1:0]                tx_ready;
  hw_fifo_req_t  [N_DMA_CH-1:0]                fifo_req;
  hw_fifo_resp_t [N_DMA_CH-1:0]                fifo_resp;
  logic          [N_DMA_CH-1:0]                busy;
  logic          [N_DMA_CH-1:0]                done;
  logic          [N_DMA_CH-1:0][DMA_LEN_W-1:0] count;

  modport master (
    output ch_type, start, len, abort, rx_valid, rx_data, tx_ready, fifo_resp,
    input  rx_ready, tx_valid, tx_data, fifo_req, busy, done, count
  );

  modport slave (
    input  ch_type, start, len, abort, rx_valid, rx_data, tx_ready, fifo_resp,
    output rx_ready, tx_valid, tx_data, fifo_req, busy, done, count
  );

endinterface

// File: rtl/hw_fifo_dma_bridge_ch.sv
// Single bridge channel: moves len words between a DMA beat port and one HW FIFO pair.
// state | meaning
// IDLE  | waiting for start; all handshakes held low
// RUN   | transferring; one beat per cycle while the FIFO allows
// DONE  | one-cycle done pulse, then back to IDLE
module hw_fifo_dma_bridge_ch
  import hw_fifo_dma_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ch_type,
  input  logic                 start,
  input  logic [DMA_LEN_W-1:0] len,
  input  logic                 abort,
  input  logic                 rx_valid,
  input  logic [DATA_W-1:0]    rx_data,
  output logic                 rx_ready,
  output logic                 tx_valid,
  output logic [DATA_W-1:0]    tx_data,
  input  logic                 tx_ready,
  output hw_fifo_req_t         fifo_req,
  input  hw_fifo_resp_t        fifo_resp,
  output logic                 busy,
  output logic                 done,
  output logic [DMA_LEN_W-1:0] count
);

  localparam logic [DMA_LEN_W-1:0] LEN_ONE = DMA_LEN_W'(1);

  dma_ch_state_e        state_q, state_d;
  logic [DMA_LEN_W-1:0] remaining_q;
  logic [DMA_LEN_W-1:0] count_q;
  logic                 in_run;
  logic                 beat;
  logic                 last_beat;
  logic                 start_ok;
  logic                 resp_push_unused;

  assign resp_push_unused = fifo_resp.push;

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    fifo_req = '0;
    beat     = 1'b0;
    in_run   = (state_q == RUN);
    start_ok = (state_q == IDLE) && start && !abort;

    if (in_run) begin
      if (ch_type) begin
        tx_valid     = !fifo_resp.empty;
        tx_data      = fifo_resp.data;
        beat         = tx_valid && tx_ready;
        fifo_req.pop = beat;
      end else begin
        rx_ready      = !fifo_resp.full;
        beat          = rx_valid && rx_ready;
        fifo_req.push = beat;
        fifo_req.data = rx_data;
      end
    end
    last_beat = beat && (remaining_q == LEN_ONE);

    unique case (state_q)
      IDLE: if (start_ok) state_d = (len != '0) ? RUN : DONE;
      // abort wins over a completing beat in the same cycle
      RUN: begin
        if (abort)          state_d = IDLE;
        else if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        remaining_q <= len;
        count_q     <= '0;
      end else if (beat && !abort) begin
        remaining_q <= remaining_q - LEN_ONE;
        count_q     <= count_q + LEN_ONE;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign count = count_q;

endmodule

// File: rtl/hw_fifo_dma_bridge.sv
// DMA-side front end of the streaming interface: one independent transfer engine per
// DMA channel, each bridging a DMA beat port to that channel's HW FIFO pair.
module hw_fifo_dma_bridge
  import hw_fifo_dma_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  hw_fifo_dma_bridge_if.slave  bus
);

  logic          [N_DMA_CH-1:0]                rx_ready;
  logic          [N_DMA_CH-1:0]                tx_valid;
  logic          [N_DMA_CH-1:0][DATA_W-1:0]    tx_data;
  hw_fifo_req_t  [N_DMA_CH-1:0]                fifo_req;
  logic          [N_DMA_CH-1:0]                busy;
  logic          [N_DMA_CH-1:0]                done;
  logic          [N_DMA_CH-1:0][DMA_LEN_W-1:0] count;

  for (genvar c = 0; c < N_DMA_CH; c++) begin : g_ch
    hw_fifo_dma_bridge_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_type   (bus.ch_type[c]),
      .start     (bus.start[c]),
      .len       (bus.len[c]),
      .abort     (bus.abort[c]),
      .rx_valid  (bus.rx_valid[c]),
      .rx_data   (bus.rx_data[c]),
      .rx_ready  (rx_ready[c]),
      .tx_valid  (tx_valid[c]),
      .tx_data   (tx_data[c]),
      .tx_ready  (bus.tx_ready[c]),
      .fifo_req  (fifo_req[c]),
      .fifo_resp (bus.fifo_resp[c]),
      .busy      (busy[c]),
      .done      (done[c]),
      .count     (count[c])
    );
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
  assign bus.fifo_req = fifo_req;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.count    = count;

endmodule

// File: tb/tb_hw_fifo_dma_bridge.sv
// Scoreboard bench: channel 0 is a read channel, channel 1 a write channel fed by a
// small FIFO model; a negedge monitor checks pushes, write beats and done counts.
module tb_hw_fifo_dma_bridge;
  import hw_fifo_dma_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hw_fifo_dma_bridge_if bus ();

  hw_fifo_dma_bridge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_push[$];
  logic [31:0] exp_tx[$];
  logic [15:0] exp_done0[$];
  logic [15:0] exp_done1[$];

  logic          rd_full = 1'b0;
  logic [31:0]   wf_data[16];
  logic [3:0]    wf_wr = 4'd0;
  logic [3:0]    wf_rd = 4'd0;
  hw_fifo_resp_t resp0, resp1;

  always_comb begin
    resp0       = '0;
    resp0.full  = rd_full;
    resp0.empty = 1'b1;
    resp1       = '0;
    resp1.empty = (wf_wr == wf_rd);
    resp1.data  = wf_data[wf_rd];
  end
  assign bus.fifo_resp = {resp1, resp0};

  always @(posedge clk) if (bus.fifo_req[1].pop) wf_rd <= wf_rd + 4'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=no_event", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int c, input string name);
    int n = 0;
    while ((bus.busy[c] || bus.done[c]) && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(bus.busy[c] | bus.done[c]), 64'd0);
  endtask

  // monitor: every DUT-presented event is matched against the scoreboard
  always @(negedge clk) begin
    logic hs;
    if (bus.fifo_req[0].push) begin
      check("push_while_full", 64'(rd_full), 64'd0);
      if (exp_push.size() == 0) unexpected("push_extra", 64'(bus.fifo_req[0].data));
      else check("push_data", 64'(bus.fifo_req[0].data), 64'(exp_push.pop_front()));
    end
    if (bus.fifo_req[0].pop) unexpected("pop_on_read_ch", 64'd1);
    if (bus.fifo_req[1].push) unexpected("push_on_write_ch", 64'd1);
    hs = bus.tx_valid[1] && bus.tx_ready[1];
    if (hs || bus.fifo_req[1].pop) check("pop_vs_handshake", 64'(bus.fifo_req[1].pop), 64'(hs));
    if (hs) begin
      if (exp_tx.size() == 0) unexpected("tx_extra", 64'(bus.tx_data[1]));
      else check("tx_data", 64'(bus.tx_data[1]), 64'(exp_tx.pop_front()));
    end
    if (bus.done[0]) begin
      if (exp_done0.size() == 0) unexpected("done0_extra", 64'(bus.count[0]));
      else check("done0_count", 64'(bus.count[0]), 64'(exp_done0.pop_front()));
    end
    if (bus.done[1]) begin
      if (exp_done1.size() == 0) unexpected("done1_extra", 64'(bus.count[1]));
      else check("done1_count", 64'(bus.count[1]), 64'(exp_done1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d[4];

    for (int i = 0; i < 16; i++) wf_data[i] = '0;
    bus.ch_type  = 2'b10;
    bus.start    = '0;
    bus.len      = '0;
    bus.abort    = '0;
    bus.rx_valid = '0;
    bus.rx_data  = '0;
    bus.tx_ready = '0;

    // reset state
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data[1]), 64'd0);
    check("rst_req0", 64'(bus.fifo_req[0]), 64'd0);
    check("rst_req1", 64'(bus.fifo_req[1]), 64'd0);
    rst_n = 1'b1;
    tick();

    // read, len=4, rx_valid held, FIFO never full
    for (int k = 0; k < 4; k++) begin
      d[k] = 32'h1111_0000 + 32'(k);
      exp_push.push_back(d[k]);
    end
    exp_done0.push_back(16'd4);
    bus.len[0] = 16'd4; bus.start[0] = 1'b1; bus.rx_valid[0] = 1'b1; bus.rx_data[0] = d[0];
    tick();
    bus.start[0] = 1'b0;
    check("t1_busy", 64'(bus.busy[0]), 64'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      bus.rx_data[0] = d[k];
    end
    tick();
    check("t1_done", 64'(bus.done[0]), 64'd1);
    check("t1_ready_done", 64'(bus.rx_ready[0]), 64'd0);
    tick();
    check("t1_ready_idle", 64'(bus.rx_ready[0]), 64'd0);
    check("t1_done_width", 64'(bus.done[0]), 64'd0);
    check("t1_count", 64'(bus.count[0]), 64'd4);
    bus.rx_valid[0] = 1'b0;

    // read, len=3, FIFO full for the first two RUN cycles
    for (int k = 0; k < 3; k++) begin
      d[k] = 32'hC0DE_0000 + 32'(k);
      exp_push.push_back(d[k]);
    end
    exp_done0.push_back(16'd3);
    rd_full = 1'b1;
    bus.len[0] = 16'd3; bus.start[0] = 1'b1; bus.rx_valid[0] = 1'b1; bus.rx_data[0] = d[0];
    tick();
    bus.start[0] = 1'b0;
    check("t2_ready_full1", 64'(bus.rx_ready[0]), 64'd0);
    tick();
    check("t2_ready_full2", 64'(bus.rx_ready[0]), 64'd0);
    rd_full = 1'b0;
    tick();
    bus.rx_data[0] = d[1];
    tick();
    bus.rx_data[0] = d[2];
    wait_idle(0, "t2_idle");
    check("t2_count", 64'(bus.count[0]), 64'd3);
    bus.rx_valid[0] = 1'b0;

    // write, len=2, tx_ready toggling
    wf_data[wf_wr] = 32'hA5A5_A5A5; wf_wr = wf_wr + 4'd1;
    wf_data[wf_wr] = 32'h5A5A_5A5A; wf_wr = wf_wr + 4'd1;
    exp_tx.push_back(32'hA5A5_A5A5);
    exp_tx.push_back(32'h5A5A_5A5A);
    exp_done1.push_back(16'd2);
    bus.len[1] = 16'd2; bus.start[1] = 1'b1; bus.tx_ready[1] = 1'b0;
    tick();
    bus.start[1] = 1'b0;
    check("t3_valid", 64'(bus.tx_valid[1]), 64'd1);
    check("t3_data0", 64'(bus.tx_data[1]), 64'hA5A5_A5A5);
    for (int k = 0; k < 4; k++) begin
      bus.tx_ready[1] = (k % 2 == 1);
      tick();
    end
    bus.tx_ready[1] = 1'b0;
    wait_idle(1, "t3_idle");
    check("t3_count", 64'(bus.count[1]), 64'd2);
    check("t3_fifo_drained", 64'(wf_rd), 64'(wf_wr));

    // len=0: straight to DONE, never busy
    exp_done0.push_back(16'd0);
    bus.len[0] = 16'd0; bus.start[0] = 1'b1;
    tick();
    bus.start[0] = 1'b0;
    check("t4_busy_a", 64'(bus.busy[0]), 64'd0);
    check("t4_done", 64'(bus.done[0]), 64'd1);
    tick();
    check("t4_busy_b", 64'(bus.busy[0]), 64'd0);
    check("t4_count", 64'(bus.count[0]), 64'd0);

    // len=8, restart attempt during RUN, abort after 3 beats
    for (int k = 0; k < 3; k++) begin
      d[k] = 32'hF00D_0000 + 32'(k);
      exp_push.push_back(d[k]);
    end
    bus.len[0] = 16'd8; bus.start[0] = 1'b1; bus.rx_valid[0] = 1'b1; bus.rx_data[0] = d[0];
    tick();
    bus.start[0] = 1'b0;
    tick();
    bus.rx_data[0] = d[1]; bus.start[0] = 1'b1; bus.len[0] = 16'd2;
    tick();
    bus.start[0] = 1'b0; bus.len[0] = 16'd0; bus.rx_data[0] = d[2];
    tick();
    bus.rx_valid[0] = 1'b0; bus.abort[0] = 1'b1;
    check("t5_count_run", 64'(bus.count[0]), 64'd3);
    check("t5_busy_run", 64'(bus.busy[0]), 64'd1);
    tick();
    bus.abort[0] = 1'b0;
    check("t5_busy_idle", 64'(bus.busy[0]), 64'd0);
    check("t5_no_done_a", 64'(bus.done[0]), 64'd0);
    check("t5_count_frozen", 64'(bus.count[0]), 64'd3);
    tick();
    check("t5_no_done_b", 64'(bus.done[0]), 64'd0);

    // reset during beat 2 of 5, then a fresh len=1 transfer
    d[0] = 32'h6060_0001; d[1] = 32'h6060_0002;
    exp_push.push_back(d[0]);
    exp_push.push_back(d[1]);
    bus.len[0] = 16'd5; bus.start[0] = 1'b1; bus.rx_valid[0] = 1'b1; bus.rx_data[0] = d[0];
    tick();
    bus.start[0] = 1'b0;
    tick();
    bus.rx_data[0] = d[1]; rst_n = 1'b0;
    tick();
    check("t6_rst_busy", 64'(bus.busy[0]), 64'd0);
    check("t6_rst_done", 64'(bus.done[0]), 64'd0);
    check("t6_rst_count", 64'(bus.count[0]), 64'd0);
    check("t6_rst_ready", 64'(bus.rx_ready[0]), 64'd0);
    check("t6_rst_req", 64'(bus.fifo_req[0]), 64'd0);
    bus.rx_valid[0] = 1'b0; rst_n = 1'b1;
    tick();
    exp_push.push_back(32'h0000_BEEF);
    exp_done0.push_back(16'd1);
    bus.len[0] = 16'd1; bus.start[0] = 1'b1; bus.rx_valid[0] = 1'b1; bus.rx_data[0] = 32'h0000_BEEF;
    tick();
    bus.start[0] = 1'b0;
    wait_idle(0, "t6_idle");
    check("t6_count", 64'(bus.count[0]), 64'd1);
    bus.rx_valid[0] = 1'b0;

    repeat (3) tick();
    check("sb_push_left", 64'(exp_push.size()), 64'd0);
    check("sb_tx_left", 64'(exp_tx.size()), 64'd0);
    check("sb_done0_left", 64'(exp_done0.size()), 64'd0);
    check("sb_done1_left", 64'(exp_done1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
